// File: rtl/ieu_pkg.sv
// ieu_pkg -- shared types and defaults for the Immediate Extension Unit.
//
// Contents:
//   ext_mode_e     extension mode selector (sign / zero / upper)
//   IEU_N_DEFAULT  default input immediate width
//   IEU_M_DEFAULT  default output datapath width
package ieu_pkg;

  typedef enum logic [1:0] {
    EXT_SIGN  = 2'd0,
    EXT_ZERO  = 2'd1,
    EXT_UPPER = 2'd2
  } ext_mode_e;

  localparam int IEU_N_DEFAULT = 16;
  localparam int IEU_M_DEFAULT = 32;

endpackage

// File: rtl/ieu_if.sv
// ieu_if -- request/result bundle between decode and the immediate extender.
//
// Signals:
//   in_valid      request strobe
//   U             0 = sign-extend, 1 = zero-extend
//   immediateIN   raw N-bit immediate
//   lui           upper-immediate select (only when IEU_LUI_EN is defined)
//   immediateOUT  registered M-bit result
//   out_valid     one-cycle pulse per accepted request
//
// Modports:
//   master  request side (decode / testbench)
//   slave   the ieu block
//
// Configuration macro: IEU_LUI_EN adds the lui signal.
interface ieu_if
  import ieu_pkg::*;
#(
  parameter int N = IEU_N_DEFAULT,
  parameter int M = IEU_M_DEFAULT
);

  logic         in_valid;
  logic         U;
  logic [N-1:0] immediateIN;
`ifdef IEU_LUI_EN
  logic         lui;
`endif
  logic [M-1:0] immediateOUT;
  logic         out_valid;

`ifdef IEU_LUI_EN
  modport master (
    output in_valid, U, immediateIN, lui,
    input  immediateOUT, out_valid
  );

  modport slave (
    input  in_valid, U, immediateIN, lui,
    output immediateOUT, out_valid
  );
`else
  modport master (
    output in_valid, U, immediateIN,
    input  immediateOUT, out_valid
  );

  modport slave (
    input  in_valid, U, immediateIN,
    output immediateOUT, out_valid
  );
`endif

endinterface

// File: rtl/ieu_extend.sv
// ieu_extend -- purely combinational N-to-M immediate extender.
//
// Ports:
//   i_mode  extension mode (EXT_SIGN, EXT_ZERO, EXT_UPPER)
//   i_imm   raw N-bit immediate
//   o_imm   extended M-bit immediate
//
// When M equals N there are no bits to fill, so every mode passes the
// immediate straight through.
module ieu_extend
  import ieu_pkg::*;
#(
  parameter int N = IEU_N_DEFAULT,
  parameter int M = IEU_M_DEFAULT
) (
  input  ext_mode_e    i_mode,
  input  logic [N-1:0] i_imm,
  output logic [M-1:0] o_imm
);

  localparam int EXT = M - N;

  logic [M-1:0] w_sign;
  logic [M-1:0] w_zero;
  logic [M-1:0] w_upper;

  // The replication count must be non-zero, so the fill logic only
  // exists when the output is strictly wider than the input.
  generate
    if (EXT > 0) begin : g_widen
      assign w_sign  = {{EXT{i_imm[N-1]}}, i_imm};
      assign w_zero  = {{EXT{1'b0}}, i_imm};
      assign w_upper = {i_imm, {EXT{1'b0}}};
    end else begin : g_pass
      assign w_sign  = i_imm;
      assign w_zero  = i_imm;
      assign w_upper = i_imm;
    end
  endgenerate

  always_comb begin
    o_imm = w_sign;
    case (i_mode)
      EXT_SIGN:  o_imm = w_sign;
      EXT_ZERO:  o_imm = w_zero;
      EXT_UPPER: o_imm = w_upper;
      default:   o_imm = w_sign;
    endcase
  end

endmodule

// File: rtl/ieu.sv
// ieu -- Immediate Extension Unit. Widens an N-bit immediate to the M-bit
// datapath using sign or zero extension, with a one-cycle registered result.
//
// Ports:
//   clk  rising-edge clock
//   rst  asynchronous active-high reset
//   bus  ieu_if.slave (in_valid, U, immediateIN, [lui], immediateOUT, out_valid)
//
// Configuration macro: IEU_LUI_EN -- when defined, lui = 1 places the
// immediate in the upper N bits with zeros below, overriding U.
module ieu
  import ieu_pkg::*;
#(
  parameter int N = IEU_N_DEFAULT,
  parameter int M = IEU_M_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  ieu_if.slave bus
);

  ext_mode_e    w_mode;
  logic [M-1:0] w_ext;
  logic [M-1:0] r_imm;
  logic         r_valid;

  // Upper-immediate placement takes priority over U when enabled.
`ifdef IEU_LUI_EN
  assign w_mode = bus.lui ? EXT_UPPER : (bus.U ? EXT_ZERO : EXT_SIGN);
`else
  assign w_mode = bus.U ? EXT_ZERO : EXT_SIGN;
`endif

  ieu_extend #(
    .N (N),
    .M (M)
  ) u_extend (
    .i_mode (w_mode),
    .i_imm  (bus.immediateIN),
    .o_imm  (w_ext)
  );

  // The result register only loads on an accepted request so it holds its
  // value through idle cycles; the valid flag simply follows in_valid, which
  // yields one pulse per request and a continuous flag for back-to-back use.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_imm   <= '0;
      r_valid <= 1'b0;
    end else begin
      r_valid <= bus.in_valid;
      if (bus.in_valid) begin
        r_imm <= w_ext;
      end
    end
  end

  assign bus.immediateOUT = r_imm;
  assign bus.out_valid    = r_valid;

endmodule

// File: tb/tb_ieu.sv
// tb_ieu -- self-checking bench for ieu (N=16, M=32) plus a pass-through
// instance (N=M=8). Expected results are queued when a request is driven
// and popped when the DUT reports out_valid.
module tb_ieu;

  logic clk;
  logic rst;

  int checks;
  int failures;

  logic [31:0] expQ[$];
  logic [31:0] heldExp;

  ieu_if #(.N(16), .M(32)) bus ();
  ieu_if #(.N(8),  .M(8))  bus8 ();

  ieu #(.N(16), .M(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  ieu #(.N(8), .M(8)) dut8 (
    .clk (clk),
    .rst (rst),
    .bus (bus8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference behaviour of the 16-to-32 extender.
  function automatic logic [31:0] model(input logic u, input logic [15:0] imm, input logic l);
    logic [31:0] r;
    if (l)
      r = {imm, 16'h0000};
    else if (!u && imm[15])
      r = {16'hFFFF, imm};
    else
      r = {16'h0000, imm};
    return r;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
    end
  endtask

  // Drive one request at the falling edge, let the DUT sample it on the
  // rising edge, then compare the registered result just after that edge.
  task automatic applyStimulus(input string tag, input logic v, input logic u,
                               input logic [15:0] imm, input logic l);
    logic [31:0] e;
    @(negedge clk);
    bus.in_valid    = v;
    bus.U           = u;
    bus.immediateIN = imm;
`ifdef IEU_LUI_EN
    bus.lui         = l;
`endif
    if (v) expQ.push_back(model(u, imm, l));
    @(posedge clk);
    #1;
    checkOutput({tag, "_valid"}, {31'd0, bus.out_valid}, {31'd0, v});
    if (v) begin
      if (expQ.size() == 0) begin
        checkOutput({tag, "_queue"}, 32'd0, 32'd1);
      end else begin
        e = expQ.pop_front();
        heldExp = e;
        checkOutput({tag, "_imm"}, bus.immediateOUT, e);
      end
    end else begin
      checkOutput({tag, "_hold"}, bus.immediateOUT, heldExp);
    end
  endtask

  initial begin
    logic v;
    logic u;
    logic [15:0] imm;

    checks   = 0;
    failures = 0;
    heldExp  = 32'd0;

    rst              = 1'b1;
    bus.in_valid     = 1'b0;
    bus.U            = 1'b0;
    bus.immediateIN  = '0;
    bus8.in_valid    = 1'b0;
    bus8.U           = 1'b0;
    bus8.immediateIN = '0;
`ifdef IEU_LUI_EN
    bus.lui          = 1'b0;
    bus8.lui         = 1'b0;
`endif

    #3;
    checkOutput("reset_imm",   bus.immediateOUT, 32'd0);
    checkOutput("reset_valid", {31'd0, bus.out_valid}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Directed cases.
    applyStimulus("sign_neg",  1'b1, 1'b0, 16'hFFF7, 1'b0);
    applyStimulus("sign_pos",  1'b1, 1'b0, 16'h0006, 1'b0);
    applyStimulus("zero_small",1'b1, 1'b1, 16'h000B, 1'b0);
    applyStimulus("zero_neg",  1'b1, 1'b1, 16'hFFFE, 1'b0);
    applyStimulus("idle",      1'b0, 1'b0, 16'h1234, 1'b0);
    applyStimulus("idle2",     1'b0, 1'b1, 16'h8000, 1'b0);
    applyStimulus("sign_min",  1'b1, 1'b0, 16'h8000, 1'b0);
    applyStimulus("sign_max",  1'b1, 1'b0, 16'h7FFF, 1'b0);

`ifdef IEU_LUI_EN
    applyStimulus("lui_u0",    1'b1, 1'b0, 16'h1234, 1'b1);
    applyStimulus("lui_u1",    1'b1, 1'b1, 16'h1234, 1'b1);
    applyStimulus("lui_neg",   1'b1, 1'b0, 16'hF00F, 1'b1);
`endif

    // Random mix of requests, idles and both extension modes.
    for (int i = 0; i < 30; i++) begin
      v   = ($urandom_range(0, 3) != 0);
      u   = $urandom_range(0, 1);
      imm = 16'($urandom);
      applyStimulus("rand", v, u, imm, 1'b0);
    end

    // Reset with a result on the output: must clear immediately.
    applyStimulus("pre_rst", 1'b1, 1'b0, 16'hABCD, 1'b0);
    @(negedge clk);
    bus.in_valid    = 1'b1;
    bus.U           = 1'b0;
    bus.immediateIN = 16'h5555;
    #2;
    rst = 1'b1;
    #1;
    checkOutput("rst_async_imm",   bus.immediateOUT, 32'd0);
    checkOutput("rst_async_valid", {31'd0, bus.out_valid}, 32'd0);
    @(posedge clk);
    #1;
    checkOutput("rst_held_valid", {31'd0, bus.out_valid}, 32'd0);
    @(negedge clk);
    bus.in_valid = 1'b0;
    rst = 1'b0;
    heldExp = 32'd0;
    applyStimulus("post_rst", 1'b0, 1'b0, 16'h0000, 1'b0);

    // Pass-through instance: output equals input regardless of U.
    @(negedge clk);
    bus8.in_valid    = 1'b1;
    bus8.U           = 1'b0;
    bus8.immediateIN = 8'h80;
    @(posedge clk);
    #1;
    checkOutput("pass_u0", {24'd0, bus8.immediateOUT}, 32'h80);
    @(negedge clk);
    bus8.U           = 1'b1;
    bus8.immediateIN = 8'hC3;
    @(posedge clk);
    #1;
    checkOutput("pass_u1", {24'd0, bus8.immediateOUT}, 32'hC3);
    checkOutput("pass_valid", {31'd0, bus8.out_valid}, 32'd1);
    @(negedge clk);
    bus8.in_valid = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ieu.md
# ieu

Immediate Extension Unit: widens an N-bit instruction immediate to the M-bit datapath width. It applies sign extension or zero extension, selected per request. It sits between instruction decode and the ALU operand mux. The result is registered, with one cycle of latency and a valid flag.

## Interface
- N, default 16: input immediate width; N ≥ 1.
- M, default 32: output width; M ≥ N, and M = N is legal (pass-through).
- clk  input  1  clock, rising-edge active.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  request strobe; inputs are sampled when it is high at a clk rising edge.
- U  input  1  extension select: 0 = signed (sign-extend), 1 = unsigned (zero-extend).
- immediateIN  input  N  raw immediate.
- immediateOUT  output  M  extended immediate (registered).
- out_valid  output  1  high for one cycle per accepted request.
- lui  input  1  upper-immediate select; exists only with IEU_LUI_EN.

## Operation
- U = 0: immediateOUT[N-1:0] = immediateIN, and bits [M-1:N] are copies of immediateIN[N-1].
- U = 1: immediateOUT[N-1:0] = immediateIN, and bits [M-1:N] = 0.
- M = N: the output equals the input for either value of U.
- Pure bit replication; no arithmetic, no overflow, no status flags.
- U is treated as a don't-care when in_valid is low.
- No back-pressure; every request is accepted.

## Timing
- Latency is one cycle. A request sampled at edge k appears on immediateOUT with out_valid = 1 after edge k.
- out_valid is high for exactly the cycle after each accepted request. Back-to-back requests give a continuous out_valid and one result per cycle.
- in_valid low at an edge: out_valid drops to 0 and immediateOUT holds its last value.
- While rst is asserted, immediateOUT = 0 and out_valid = 0, independent of clk.
- Reset mid-operation: an in-flight result is discarded and no out_valid pulse is produced for it.
- Release of rst is synchronous in effect; the first sample occurs at the first clk edge after deassertion.

## Configuration
- Macro: IEU_LUI_EN.
- Defined: adds the lui port.
  - lui = 1 (requires M ≥ N): immediateOUT = {immediateIN, (M-N) zeros}, and U is ignored.
  - lui = 0: normal extension as in Operation.
- Undefined: no lui port; only sign/zero extension.

## Structure
- Package ieu_pkg holds:
  - ext_mode_e: EXT_SIGN = 0, EXT_ZERO = 1, EXT_UPPER.
  - IEU_N_DEFAULT = 16 and IEU_M_DEFAULT = 32.
- Sub-module ieu_extend: purely combinational N→M extender with mode input.
- ieu instantiates ieu_extend and owns the output/valid registers and reset.

## Test plan
- U = 0, immediateIN = 0xFFF7 (-9), in_valid = 1 -> next cycle immediateOUT = 0xFFFFFFF7, out_valid = 1.
- U = 0, immediateIN = 0x0006 -> immediateOUT = 0x00000006.
- U = 1, immediateIN = 0x000B -> immediateOUT = 0x0000000B. Then U = 1, immediateIN = 0xFFFE (-2) -> immediateOUT = 0x0000FFFE, with out_valid high on both consecutive cycles.
- Hold: after a result of 0x0000FFFE, drive in_valid = 0 with immediateIN = 0x1234 -> out_valid = 0 and immediateOUT stays 0x0000FFFE.
- Reset: with a request in flight, assert rst between edges -> immediateOUT = 0 and out_valid = 0 immediately; no pulse after release.
- IEU_LUI_EN defined: lui = 1, immediateIN = 0x1234 -> immediateOUT = 0x12340000, for either value of U.
